// File: rtl/dcdc_clkgen_pkg.sv
// Shared constants for the frame-synchronous DC-DC converter clock generator:
// register field indices, prescaler select encodings and dither LFSR setup.
package dcdc_clkgen_pkg;

    localparam logic FLD_DIV   = 1'b0;
    localparam logic FLD_PHASE = 1'b1;

    typedef enum logic [1:0] {
        SelDiv1    = 2'd0,
        SelDiv16   = 2'd1,
        SelDiv256  = 2'd2,
        SelDiv4096 = 2'd3
    } presc_sel_e;

    localparam int unsigned PRESC_W = 12;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] presc_ticks(input logic [PRESC_W-1:0] cnt);
        logic [3:0] t;
        t             = '0;
        t[SelDiv1]    = 1'b1;
        t[SelDiv16]   = &cnt[3:0];
        t[SelDiv256]  = &cnt[7:0];
        t[SelDiv4096] = &cnt[11:0];
        return t;
    endfunction

endpackage

// File: rtl/dcdc_clkgen_ch.sv
// One converter clock channel: active/pending config, half-period counter,
// frame-aligned resync and the registered converter clock/external flag.
module dcdc_clkgen_ch
    import dcdc_clkgen_pkg::*;
#(
    parameter int unsigned DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_i,
    input  logic             we_div_i,
    input  logic             we_phase_i,
    input  logic [DIV_W+1:0] wd_i,
    input  logic [3:0]       tick_i,
    input  logic             dith_i,
    output logic             cnvclk_o,
    output logic             cnvext_o,
    output logic             pend_o
);

    localparam int unsigned CNT_W = DIV_W + 1;

    logic [1:0]       act_sel_q, act_sel_d, pnd_sel_q, pnd_sel_d;
    logic [DIV_W-1:0] act_div_q, act_div_d, pnd_div_q, pnd_div_d;
    logic [DIV_W-1:0] act_phase_q, act_phase_d, pnd_phase_q, pnd_phase_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cntr_q, cntr_d;
    logic             cnvclk_q, cnvclk_d;
    logic             fullper_q, fullper_d;
    logic             cnvext_q;

    logic             apply;
    logic [1:0]       eff_sel;
    logic [DIV_W-1:0] eff_div, eff_phase;
    logic             tick, sync;

    // On a frame with a pending config, this cycle already runs on the new values
    assign apply     = frame_i && valid_q;
    assign eff_sel   = apply ? pnd_sel_q   : act_sel_q;
    assign eff_div   = apply ? pnd_div_q   : act_div_q;
    assign eff_phase = apply ? pnd_phase_q : act_phase_q;
    assign tick      = tick_i[eff_sel];
    assign sync      = frame_i && (valid_q || fullper_q);

    always_comb begin
        act_sel_d   = act_sel_q;
        act_div_d   = act_div_q;
        act_phase_d = act_phase_q;
        pnd_sel_d   = pnd_sel_q;
        pnd_div_d   = pnd_div_q;
        pnd_phase_d = pnd_phase_q;
        valid_d     = valid_q;
        if (apply) begin
            act_sel_d   = pnd_sel_q;
            act_div_d   = pnd_div_q;
            act_phase_d = pnd_phase_q;
            valid_d     = 1'b0;
        end
        // A channel that is off takes writes immediately; a running one waits for frame
        if (we_div_i) begin
            pnd_sel_d = wd_i[DIV_W+1:DIV_W];
            pnd_div_d = wd_i[DIV_W-1:0];
            if (act_div_q == '0) begin
                act_sel_d = wd_i[DIV_W+1:DIV_W];
                act_div_d = wd_i[DIV_W-1:0];
            end else begin
                valid_d = 1'b1;
            end
        end
        if (we_phase_i) begin
            pnd_phase_d = wd_i[DIV_W-1:0];
            if (act_div_q == '0) begin
                act_phase_d = wd_i[DIV_W-1:0];
            end else begin
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        cntr_d    = cntr_q;
        cnvclk_d  = cnvclk_q;
        fullper_d = fullper_q;
        if (eff_div == '0) begin
            cntr_d    = '0;
            cnvclk_d  = 1'b0;
            fullper_d = 1'b0;
        end else if (sync) begin
            cntr_d    = CNT_W'(eff_div) + CNT_W'(eff_phase);
            cnvclk_d  = 1'b0;
            fullper_d = 1'b0;
        end else if (tick && cntr_q == '0) begin
            cntr_d    = CNT_W'(eff_div) + CNT_W'(dith_i);
            cnvclk_d  = ~cnvclk_q;
            fullper_d = fullper_q | cnvclk_q;
        end else if (tick) begin
            cntr_d = cntr_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sel_q   <= '0;
            act_div_q   <= '0;
            act_phase_q <= '0;
            pnd_sel_q   <= '0;
            pnd_div_q   <= '0;
            pnd_phase_q <= '0;
            valid_q     <= 1'b0;
            cntr_q      <= '0;
            cnvclk_q    <= 1'b0;
            fullper_q   <= 1'b0;
            cnvext_q    <= 1'b0;
        end else begin
            act_sel_q   <= act_sel_d;
            act_div_q   <= act_div_d;
            act_phase_q <= act_phase_d;
            pnd_sel_q   <= pnd_sel_d;
            pnd_div_q   <= pnd_div_d;
            pnd_phase_q <= pnd_phase_d;
            valid_q     <= valid_d;
            cntr_q      <= cntr_d;
            cnvclk_q    <= cnvclk_d;
            fullper_q   <= fullper_d;
            cnvext_q    <= (act_div_q != '0);
        end
    end

    assign cnvclk_o = cnvclk_q;
    assign cnvext_o = cnvext_q;
    assign pend_o   = valid_q;

endmodule

// File: rtl/dcdc_clkgen.sv
// Multi-channel frame-synchronous converter clock generator: shared prescaler,
// register decode and per-channel generators. DCDC_SPREAD_EN adds LFSR reload dither.
module dcdc_clkgen
    import dcdc_clkgen_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = 5,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned AW    = CH_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DIV_W+1:0] wd,
    output logic [NUM_CH-1:0] cnvclk,
    output logic [NUM_CH-1:0] cnvext,
    output logic [NUM_CH-1:0] pend
);

    logic [PRESC_W-1:0] presc_q;
    logic [3:0]         ticks;
    logic [NUM_CH-1:0]  dith;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    assign ticks = presc_ticks(presc_q);

`ifdef DCDC_SPREAD_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_dith
        assign dith[i] = lfsr_q[i % 8];
    end
`else
    assign dith = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;

        assign hit = we && (wa[AW-1:1] == CH_W'(i));

        dcdc_clkgen_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .frame_i   (frame),
            .we_div_i  (hit && (wa[0] == FLD_DIV)),
            .we_phase_i(hit && (wa[0] == FLD_PHASE)),
            .wd_i      (wd),
            .tick_i    (ticks),
            .dith_i    (dith[i]),
            .cnvclk_o  (cnvclk[i]),
            .cnvext_o  (cnvext[i]),
            .pend_o    (pend[i])
        );
    end

endmodule

// File: tb/tb_dcdc_clkgen.sv
// Directed self-checking bench for dcdc_clkgen (NUM_CH=2, DIV_W=5).
// With DCDC_SPREAD_EN defined it checks the dithered half-periods instead.
module tb_dcdc_clkgen;

    localparam int FD = 0;
    localparam int FP = 1;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       we;
    logic [1:0] wa;
    logic [6:0] wd;
    logic [1:0] cnvclk;
    logic [1:0] cnvext;
    logic [1:0] pend;

    int n_chk  = 0;
    int n_pass = 0;

    dcdc_clkgen #(
        .NUM_CH(2),
        .DIV_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .frame (frame),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .cnvclk(cnvclk),
        .cnvext(cnvext),
        .pend  (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DCDC_SPREAD_EN
    logic [7:0] m_q, m_prev;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 8'h01;
            m_prev <= 8'h01;
        end else begin
            m_prev <= m_q;
            m_q    <= lfsr_next(m_q);
        end
    end
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int fld, input int data);
        we = 1'b1;
        wa = 2'(ch * 2 + fld);
        wd = 7'(data);
        step();
        we = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        step();
        frame = 1'b0;
    endtask

    // Cycles until cnvclk[ch] changes; an expired bound is reported as a failure
    task automatic wait_toggle(input string tag, input int ch, input int bound, output int cyc);
        logic prev;
        prev = cnvclk[ch];
        cyc  = 0;
        do begin
            step();
            cyc++;
        end while (cnvclk[ch] === prev && cyc < bound);
        chk({tag, " toggled"}, int'(cnvclk[ch] !== prev), 1);
    endtask

    task automatic wait_level(input string tag, input int ch, input logic lvl);
        int cyc;
        cyc = 0;
        while (cnvclk[ch] !== lvl && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, " level"}, int'(cnvclk[ch]), int'(lvl));
    endtask

    initial begin
        int c, c0, c1;
        rst   = 1'b1;
        frame = 1'b0;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        repeat (2) step();
        chk("rst cnvclk", int'(cnvclk), 0);
        chk("rst cnvext", int'(cnvext), 0);
        chk("rst pend", int'(pend), 0);
        rst = 1'b0;
        step();

`ifdef DCDC_SPREAD_EN
        begin
            int b;
            wr(0, FD, 4);
            wait_toggle("sp first", 0, 10, c);
            b = int'(m_prev[0]);
            for (int k = 0; k < 10; k++) begin
                wait_toggle("sp half", 0, 20, c);
                chk("sp half len", c, 5 + b);
                b = int'(m_prev[0]);
            end
        end
`else
        // Channel off: write lands in active directly
        wr(0, FD, 4);
        chk("t1 pend", int'(pend[0]), 0);
        chk("t1 cnvext t+1", int'(cnvext[0]), 0);
        chk("t1 cnvclk t+1", int'(cnvclk[0]), 0);
        step();
        chk("t1 cnvext t+2", int'(cnvext[0]), 1);
        chk("t1 cnvclk t+2", int'(cnvclk[0]), 1);
        wait_toggle("t1 h0", 0, 20, c);
        chk("t1 half a", c, 5);
        wait_toggle("t1 h1", 0, 20, c);
        chk("t1 half b", c, 5);
        chk("t1 pend idle", int'(pend[0]), 0);

        // Running channel: new div waits for frame
        wr(0, FD, 9);
        chk("t2 pend set", int'(pend[0]), 1);
        wait_toggle("t2 align", 0, 20, c);
        wait_toggle("t2 h0", 0, 20, c);
        chk("t2 half old a", c, 5);
        wait_toggle("t2 h1", 0, 20, c);
        chk("t2 half old b", c, 5);
        wait_level("t2 high", 0, 1'b1);
        pulse_frame();
        chk("t2 frame cnvclk", int'(cnvclk[0]), 0);
        chk("t2 frame pend", int'(pend[0]), 0);
        wait_toggle("t2 h2", 0, 30, c);
        chk("t2 half new a", c, 10);
        wait_toggle("t2 h3", 0, 30, c);
        chk("t2 half new b", c, 10);

        // Phase stagger between ch0 and ch1
        wr(1, FP, 3);
        wr(1, FD, 4);
        wr(0, FD, 4);
        chk("t3 pend", int'(pend), 1);
        repeat (20) step();
        pulse_frame();
        chk("t3 frame cnvclk", int'(cnvclk), 0);
        chk("t3 frame pend", int'(pend), 0);
        c0 = 0;
        c1 = 0;
        for (int k = 1; k <= 20 && (c0 == 0 || c1 == 0); k++) begin
            step();
            if (c0 == 0 && cnvclk[0] === 1'b1) c0 = k;
            if (c1 == 0 && cnvclk[1] === 1'b1) c1 = k;
        end
        chk("t3 ch0 rise", c0, 5);
        chk("t3 ch1 rise", c1, 8);
        chk("t3 lag", c1 - c0, 3);
        wait_toggle("t3 ch1 h0", 1, 20, c);
        chk("t3 ch1 half a", c, 5);
        wait_toggle("t3 ch1 h1", 1, 20, c);
        chk("t3 ch1 half b", c, 5);
        wait_toggle("t3 ch0 align", 0, 20, c);
        wait_toggle("t3 ch0 h", 0, 20, c);
        chk("t3 ch0 half", c, 5);

        // Prescaled channel, frame ignored before first full period
        wr(0, FD, (1 << 5) | 1);
        pulse_frame();
        wait_toggle("t4 rise", 0, 64, c);
        repeat (10) step();
        pulse_frame();
        chk("t4 ignored frame", int'(cnvclk[0]), 1);
        wait_toggle("t4 h0", 0, 64, c);
        chk("t4 half rest", c, 21);
        wait_toggle("t4 h1", 0, 64, c);
        chk("t4 half full", c, 32);

        // Write and frame in the same cycle
        wr(0, FD, 4);
        chk("t5 pend a", int'(pend[0]), 1);
        frame = 1'b1;
        wr(0, FD, 9);
        frame = 1'b0;
        chk("t5 pend kept", int'(pend[0]), 1);
        chk("t5 cnvclk sync", int'(cnvclk[0]), 0);
        wait_toggle("t5 h0", 0, 20, c);
        chk("t5 half old a", c, 5);
        wait_toggle("t5 h1", 0, 20, c);
        chk("t5 half old b", c, 5);
        pulse_frame();
        chk("t5 pend clr", int'(pend[0]), 0);
        wait_toggle("t5 h2", 0, 30, c);
        chk("t5 half new", c, 10);

        // Async reset mid-period
        wr(1, FD, 6);
        chk("t6 pend", int'(pend), 2);
        wait_level("t6 high", 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst cnvclk", int'(cnvclk), 0);
        chk("t6 rst cnvext", int'(cnvext), 0);
        chk("t6 rst pend", int'(pend), 0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
